// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the unified memory path:
// response tags and default timing constants.
package rv32_mem_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_I    = 2'd1,
        TAG_D    = 2'd2
    } tag_e;

    localparam int MEM_LAT_DEF    = 1;
    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/resp_tag_pipe.sv
// Fixed-depth shift register of response tags.
// The last stage names the owner of the current m_rdata.
module resp_tag_pipe
    import rv32_mem_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] tag_i,
    output logic [1:0] tag_o
);

    tag_e pipe_q [MEM_LAT];

    // Shift one tag per cycle; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MEM_LAT; k++) begin
                pipe_q[k] <= TAG_NONE;
            end
        end else begin
            pipe_q[0] <= tag_e'(tag_i);
            for (int k = 1; k < MEM_LAT; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign tag_o = pipe_q[MEM_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of one single-port memory.
// Data wins collisions; a streak counter bounds fetch wait.
module mem_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int AW         = 32,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata
);

    localparam logic [3:0]    SMAX       = 4'(STARVE_MAX);
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

    logic [3:0] streak_q;
    logic [3:0] streak_d;
    logic       fetch_prio;
    logic [1:0] tag_in;
    logic [1:0] tag_last;

    assign fetch_prio = (streak_q == SMAX);

    // Grants are combinational; data wins unless fetch is starved
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (i_req && (!d_req || fetch_prio)) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    // Count data grants that overtook a waiting fetch
    always_comb begin
        streak_d = streak_q;
        if (!i_req || i_gnt) begin
            streak_d = '0;
        end else if (d_gnt && streak_q != SMAX) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // Streak register
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    // Steer the granted port onto the memory and tag the read
    always_comb begin
        m_we    = 1'b0;
        m_be    = 4'h0;
        m_addr  = d_addr & ALIGN_MASK;
        m_wdata = d_wdata;
        tag_in  = TAG_NONE;
        if (d_gnt) begin
            m_we   = d_we;
            m_be   = d_be;
            tag_in = d_we ? TAG_NONE : TAG_D;
        end else if (i_gnt) begin
            m_be   = 4'hF;
            m_addr = i_addr & ALIGN_MASK;
            tag_in = TAG_I;
        end
    end

    assign m_en = i_gnt | d_gnt;

    resp_tag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tags (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tag_in),
        .tag_o (tag_last)
    );

    assign i_rvalid = (tag_last == TAG_I);
    assign d_rvalid = (tag_last == TAG_D);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule
